// File: rtl/mcs48_sound_bridge.sv
// ============================================================================
// mcs48_sound_bridge: 8035 sound CPU glue (ALE latch, loadable program RAM,
// command FIFO, trigger port, DAC output). Optional SND_BRIDGE_DAC_LPF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mcs48_sound_bridge #(
  parameter int ROM_AW    = 12,
  parameter int CMD_W     = 5,
  parameter int FIFO_AW   = 2,
  parameter int LPF_SHIFT = 3
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_DL_START,
  input  logic             I_DL_VALID,
  input  logic [7:0]       I_DL_DATA,
  output logic             O_DL_READY,
  input  logic [CMD_W-1:0] I_SOUND_DAT,
  input  logic             I_SOUND_WR,
  input  logic [4:0]       I_SOUND_CNT,
  input  logic [7:0]       I8035_DBI,
  output logic [7:0]       I8035_DBO,
  input  logic [7:0]       I8035_PAI,
  input  logic [7:0]       I8035_PBI,
  output logic [7:0]       I8035_PBO,
  input  logic             I8035_ALE,
  input  logic             I8035_RDn,
  input  logic             I8035_PSENn,
  output logic             I8035_RSTn,
  output logic             I8035_INTn,
  output logic             I8035_T0,
  output logic             I8035_T1,
  output logic             O_FIFO_OVF,
  output logic [7:0]       O_SOUND_DAT
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;
  localparam int RAM_DEPTH  = 1 << ROM_AW;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic              ale_q, wr_q, rd_q;
  logic [7:0]        addr_lo_q;
  logic [0:0]        state_q, state_d;
  logic [ROM_AW-1:0] dl_addr_q, dl_addr_d;
  logic              ram_we;
  logic [ROM_AW-1:0] rd_addr;
  logic [7:0]        ram_q [0:RAM_DEPTH-1];
  logic [7:0]        rom_q;

  logic [CMD_W-1:0]  fifo_q [0:FIFO_DEPTH-1];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]  cnt_q, cnt_d;
  logic [CMD_W-1:0]  last_cmd_q;
  logic              ovf_q;
  logic              push_req, pop_req, fifo_empty, fifo_full, do_push, do_pop, drop;
  logic [CMD_W-1:0]  cmd_rd;

  logic [7:0]        dbo_q, pbo_q;
  logic              rstn_q, intn_q, t0_q, t1_q;

  logic              unused_ok;
  assign unused_ok = ^I8035_PBI[7:ROM_AW-8];

  // Loader: DL_START always restarts, the last address ends the download
  always_comb begin
    state_d   = state_q;
    dl_addr_d = dl_addr_q;
    ram_we    = 1'b0;
    if (I_DL_START) begin
      state_d   = ST_LOAD;
      dl_addr_d = '0;
    end else if (state_q == ST_LOAD && I_DL_VALID) begin
      ram_we    = 1'b1;
      dl_addr_d = dl_addr_q + ROM_AW'(1);
      if (dl_addr_q == '1) state_d = ST_IDLE;
    end
  end

  assign O_DL_READY = (state_q == ST_LOAD);
  assign rd_addr    = {I8035_PBI[ROM_AW-9:0], addr_lo_q};

  always_ff @(posedge I_CLK) begin
    if (ram_we && !I_RST) ram_q[dl_addr_q] <= I_DL_DATA;
    rom_q <= ram_q[rd_addr];
  end

  assign push_req   = I_SOUND_WR & ~wr_q;
  assign pop_req    = I8035_RDn & ~rd_q & I8035_PSENn;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign do_pop     = pop_req & ~fifo_empty & ~I_DL_START;
  // A pop on a full FIFO frees the slot for a push in the same cycle
  assign do_push    = push_req & (~fifo_full | do_pop) & ~I_DL_START;
  assign drop       = push_req & fifo_full & ~do_pop & ~I_DL_START;
  assign cmd_rd     = fifo_empty ? last_cmd_q : fifo_q[rp_q];

  always_comb begin
    cnt_d = cnt_q;
    if (I_DL_START)          cnt_d = '0;
    else if (do_push && !do_pop) cnt_d = cnt_q + (FIFO_AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (FIFO_AW+1)'(1);
  end

  always_ff @(posedge I_CLK) begin
    if (do_push) fifo_q[wp_q] <= I_SOUND_DAT;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      ale_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b1;
      addr_lo_q  <= 8'h00;
      state_q    <= ST_IDLE;
      dl_addr_q  <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      last_cmd_q <= '0;
      ovf_q      <= 1'b0;
      dbo_q      <= 8'h00;
      pbo_q      <= 8'h70;
      rstn_q     <= 1'b0;
      intn_q     <= 1'b1;
      t0_q       <= 1'b1;
      t1_q       <= 1'b1;
    end else begin
      ale_q     <= I8035_ALE;
      wr_q      <= I_SOUND_WR;
      rd_q      <= I8035_RDn;
      if (ale_q && !I8035_ALE) addr_lo_q <= I8035_DBI;
      state_q   <= state_d;
      dl_addr_q <= dl_addr_d;
      cnt_q     <= cnt_d;
      if (I_DL_START) begin
        wp_q  <= '0;
        rp_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (do_push) wp_q <= wp_q + FIFO_AW'(1);
        if (do_pop) begin
          rp_q       <= rp_q + FIFO_AW'(1);
          last_cmd_q <= fifo_q[rp_q];
        end
        if (drop) ovf_q <= 1'b1;
      end
      if (!I8035_PSENn)   dbo_q <= rom_q;
      else if (!I8035_RDn) dbo_q <= 8'(cmd_rd);
      else                dbo_q <= 8'h00;
      pbo_q  <= {1'b0, ~I_SOUND_CNT[0], ~I_SOUND_CNT[4], ~I_SOUND_CNT[1], 4'b0000};
      t0_q   <= ~I_SOUND_CNT[2];
      t1_q   <= ~I_SOUND_CNT[3];
      rstn_q <= (state_q == ST_IDLE);
      intn_q <= fifo_empty;
    end
  end

  assign I8035_DBO  = dbo_q;
  assign I8035_PBO  = pbo_q;
  assign I8035_RSTn = rstn_q;
  assign I8035_INTn = intn_q;
  assign I8035_T0   = t0_q;
  assign I8035_T1   = t1_q;
  assign O_FIFO_OVF = ovf_q;

`ifdef SND_BRIDGE_DAC_LPF_EN
  localparam int ACC_W = 8 + LPF_SHIFT;
  logic [ACC_W-1:0]  acc_q;
  logic signed [ACC_W:0] lpf_diff, lpf_step;

  // First-order IIR: acc moves 1/2^LPF_SHIFT of the way toward the scaled sample
  assign lpf_diff = $signed({1'b0, I8035_PAI, {LPF_SHIFT{1'b0}}}) - $signed({1'b0, acc_q});
  assign lpf_step = lpf_diff >>> LPF_SHIFT;

  always_ff @(posedge I_CLK) begin
    if (I_RST) acc_q <= '0;
    else       acc_q <= acc_q + lpf_step[ACC_W-1:0];
  end

  assign O_SOUND_DAT = acc_q[ACC_W-1 -: 8];
`else
  localparam int unused_lpf_shift = LPF_SHIFT;
  logic [7:0] snd_q;

  always_ff @(posedge I_CLK) begin
    if (I_RST) snd_q <= 8'h00;
    else       snd_q <= I8035_PAI;
  end

  assign O_SOUND_DAT = snd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mcs48_sound_bridge.sv
// Self-checking bench for mcs48_sound_bridge (default parameters).
`default_nettype none

module tb_mcs48_sound_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       dl_start, dl_valid;
  logic [7:0] dl_data;
  logic       dl_ready;
  logic [4:0] snd_dat;
  logic       snd_wr;
  logic [4:0] snd_cnt;
  logic [7:0] dbi, dbo, pai, pbi, pbo;
  logic       ale, rdn, psenn;
  logic       rstn, intn, t0, t1, ovf;
  logic [7:0] sound;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_cmd[$];
  logic [7:0] sb_rom[$];
  logic [7:0] model_last;
  logic       model_ovf;

  always #5 clk = ~clk;

  mcs48_sound_bridge #(.ROM_AW(12), .CMD_W(5), .FIFO_AW(2), .LPF_SHIFT(3)) dut (
    .I_CLK(clk), .I_RST(rst),
    .I_DL_START(dl_start), .I_DL_VALID(dl_valid), .I_DL_DATA(dl_data), .O_DL_READY(dl_ready),
    .I_SOUND_DAT(snd_dat), .I_SOUND_WR(snd_wr), .I_SOUND_CNT(snd_cnt),
    .I8035_DBI(dbi), .I8035_DBO(dbo), .I8035_PAI(pai), .I8035_PBI(pbi), .I8035_PBO(pbo),
    .I8035_ALE(ale), .I8035_RDn(rdn), .I8035_PSENn(psenn),
    .I8035_RSTn(rstn), .I8035_INTn(intn), .I8035_T0(t0), .I8035_T1(t1),
    .O_FIFO_OVF(ovf), .O_SOUND_DAT(sound)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] v);
    if (sb_cmd.size() < 4) sb_cmd.push_back(v);
    else model_ovf = 1'b1;
    snd_dat = v[4:0];
    snd_wr = 1'b1;
    tick();
    snd_wr = 1'b0;
    tick();
  endtask

  task automatic read_cmd(input string name);
    logic [7:0] exp;
    rdn = 1'b0;
    tick();
    tick();
    exp = (sb_cmd.size() > 0) ? sb_cmd[0] : model_last;
    checks++;
    if (dbo !== exp) begin
      errors++;
      $display("FAIL %s: DBO got %02h expected %02h", name, dbo, exp);
    end
    rdn = 1'b1;
    if (sb_cmd.size() > 0) model_last = sb_cmd.pop_front();
    tick();
    tick();
  endtask

  task automatic rom_read(input logic [3:0] pb, input logic [7:0] lo, input logic [7:0] exp);
    logic [7:0] want;
    sb_rom.push_back(exp);
    pbi = {4'h0, pb};
    dbi = lo;
    ale = 1'b1;
    tick();
    ale = 1'b0;
    psenn = 1'b0;
    tick();
    tick();
    tick();
    want = sb_rom.pop_front();
    checks++;
    if (dbo !== want) begin
      errors++;
      $display("FAIL rom_read %h%02h: DBO got %02h expected %02h", pb, lo, dbo, want);
    end
    psenn = 1'b1;
    tick();
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({dbo, pbo, sound} !== {8'h00, 8'h70, 8'h00}) begin
      errors++;
      $display("FAIL reset_bytes: DBO/PBO/SND got %02h/%02h/%02h expected 00/70/00", dbo, pbo, sound);
    end
    checks++;
    if ({rstn, intn, t0, t1, ovf, dl_ready} !== 6'b011100) begin
      errors++;
      $display("FAIL reset_bits: got %b expected 011100", {rstn, intn, t0, t1, ovf, dl_ready});
    end
  endtask

  task automatic test_download();
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    check_bit("dl_ready_start", dl_ready, 1'b1);
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] a;
      a = 12'(i);
      dl_valid = 1'b1;
      dl_data = a[7:0] ^ 8'h5A;
      if (i == 4095) check_bit("dl_ready_last", dl_ready, 1'b1);
      tick();
    end
    dl_valid = 1'b0;
    check_bit("dl_ready_done", dl_ready, 1'b0);
    tick();
    check_bit("rstn_after_load", rstn, 1'b1);
    rom_read(4'h1, 8'h23, 8'h79);
    rom_read(4'h0, 8'h00, 8'h5A);
    rom_read(4'hF, 8'hFF, 8'hA5);
    rom_read(4'h7, 8'h3C, 8'h66);
  endtask

  task automatic test_fifo();
    push_cmd(8'h11);
    push_cmd(8'h12);
    push_cmd(8'h13);
    check_bit("intn_pending", intn, 1'b0);
    read_cmd("fifo_rd1");
    read_cmd("fifo_rd2");
    read_cmd("fifo_rd3");
    check_bit("intn_drained", intn, 1'b1);
    read_cmd("fifo_rd_last");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) push_cmd(8'h0A + 8'(i));
    check_bit("ovf_set", ovf, model_ovf);
    for (int i = 0; i < 4; i++) read_cmd("ovf_rd");
    check_bit("intn_after_ovf", intn, 1'b1);
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    model_ovf = 1'b0;
    check_bit("ovf_clear", ovf, model_ovf);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    model_last = 8'h00;
    check_bit("ready_after_rst", dl_ready, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) push_cmd(8'h15 + 8'(i));
    rdn = 1'b0;
    tick();
    tick();
    exp = sb_cmd[0];
    checks++;
    if (dbo !== exp) begin
      errors++;
      $display("FAIL b2b_head: DBO got %02h expected %02h", dbo, exp);
    end
    model_last = sb_cmd.pop_front();
    sb_cmd.push_back(8'h1D);
    snd_dat = 5'h1D;
    snd_wr = 1'b1;
    rdn = 1'b1;
    tick();
    snd_wr = 1'b0;
    tick();
    tick();
    check_bit("b2b_no_ovf", ovf, 1'b0);
    for (int i = 0; i < 3; i++) read_cmd("b2b_rd");
    check_bit("b2b_intn_one_left", intn, 1'b0);
    read_cmd("b2b_rd_last");
    check_bit("b2b_intn_empty", intn, 1'b1);
  endtask

  task automatic test_triggers();
    logic [4:0] pats [4];
    pats[0] = 5'b10101;
    pats[1] = 5'b00000;
    pats[2] = 5'b11111;
    pats[3] = 5'b01010;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] exp;
      logic [4:0] c;
      c = pats[k];
      exp = {1'b0, ~c[0], ~c[4], ~c[1], 4'b0000, ~c[2], ~c[3]};
      snd_cnt = c;
      tick();
      tick();
      checks++;
      if ({pbo, t0, t1} !== exp) begin
        errors++;
        $display("FAIL trig %b: PBO/T0/T1 got %02h/%b/%b expected %02h/%b/%b",
                 c, pbo, t0, t1, exp[9:2], exp[1], exp[0]);
      end
    end
    snd_cnt = 5'b00000;
    tick();
  endtask

  task automatic test_reset_midload();
    dl_start = 1'b1;
    tick();
    dl_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dl_valid = 1'b1;
      dl_data = 8'hC0 + 8'(i);
      tick();
    end
    dl_valid = 1'b0;
    check_bit("midload_ready", dl_ready, 1'b1);
    psenn = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_bit("midload_rst_ready", dl_ready, 1'b0);
    check_bit("midload_rst_rstn", rstn, 1'b0);
    checks++;
    if (dbo !== 8'h00) begin
      errors++;
      $display("FAIL midload_rst_dbo: got %02h expected 00", dbo);
    end
    rst = 1'b0;
    psenn = 1'b1;
    model_last = 8'h00;
    tick();
    tick();
    rom_read(4'h0, 8'h02, 8'hC2);
    rom_read(4'h0, 8'h10, 8'h4A);
    rom_read(4'hF, 8'hFF, 8'hA5);
  endtask

  task automatic test_dac();
`ifdef SND_BRIDGE_DAC_LPF_EN
    logic [7:0] prev;
    prev = sound;
    pai = 8'h80;
    for (int i = 0; i < 48; i++) begin
      tick();
      checks++;
      if (sound < prev || sound > 8'h80) begin
        errors++;
        $display("FAIL lpf_monotonic cyc %0d: got %02h previous %02h", i, sound, prev);
      end
      prev = sound;
    end
    checks++;
    if (sound < 8'h7F) begin
      errors++;
      $display("FAIL lpf_settle: got %02h expected >= 7f", sound);
    end
`else
    logic [7:0] vals [3];
    vals[0] = 8'h80;
    vals[1] = 8'h33;
    vals[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      pai = vals[i];
      tick();
      checks++;
      if (sound !== vals[i]) begin
        errors++;
        $display("FAIL dac_follow: got %02h expected %02h", sound, vals[i]);
      end
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    dl_start = 1'b0; dl_valid = 1'b0; dl_data = 8'h00;
    snd_dat = '0; snd_wr = 1'b0; snd_cnt = 5'b00000;
    dbi = 8'h00; pai = 8'h00; pbi = 8'h00;
    ale = 1'b0; rdn = 1'b1; psenn = 1'b1;
    model_last = 8'h00;
    model_ovf = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_download();
    test_fifo();
    test_overflow();
    test_back_to_back();
    test_triggers();
    test_reset_midload();
    test_dac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
